aw_write_sched: RTL and testbench

- Write-transaction scheduler for the shared interconnect write path.
- Arbitrates AW requests from M1 (CPU) and M2 (DMA) round-robin.
- Holds the grant through the W burst and the B response, so the W and B muxes stay locked to one master per transaction.
- Latches AWLEN, counts W beats and flags WLAST mismatches; sits beside the AW arbiter/decoder and drives their master-select.

---
 rtl/aw_write_sched.sv | 182 ++++++++++++++++++
 tb/tb_aw_write_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aw_write_sched.sv
// aw_write_sched: write-path scheduler for the shared interconnect.
// Arbitrates AW requests from M1 (CPU) and M2 (DMA) round-robin and holds the
// grant through the W burst and the B response, so the W/B muxes stay locked
// to one master per transaction. Latches AWLEN, counts W beats and flags
// WLAST/beat-count mismatches.
//
// Optional feature macro: AW_SCHED_TIMEOUT_EN (adds a DATA/RESP timeout and
// the timeout_err output).
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   AWVALID_Mx, AWLEN_Mx      master address requests and burst lengths
//   AWREADY_S                 ready from the decoded slave
//   AWVALID_S, AWREADY_Mx     address handshake toward slave / masters (comb)
//   grant                     one-hot master select (bit0=M1, bit1=M2)
//   WVALID/WREADY/WLAST       muxed W channel of the granted path
//   BVALID/BREADY             muxed B channel of the granted path
//   busy                      high whenever not IDLE
//   wlast_err                 one-cycle pulse on WLAST/beat-count mismatch
//   timeout_err               one-cycle pulse on response timeout (optional)
module aw_write_sched #(
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned TO_W   = 8,
    parameter int unsigned TO_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             AWVALID_M1,
    input  logic             AWVALID_M2,
    input  logic [LEN_W-1:0] AWLEN_M1,
    input  logic [LEN_W-1:0] AWLEN_M2,
    input  logic             AWREADY_S,
    output logic             AWVALID_S,
    output logic             AWREADY_M1,
    output logic             AWREADY_M2,
    output logic [1:0]       grant,
    input  logic             WVALID,
    input  logic             WREADY,
    input  logic             WLAST,
    input  logic             BVALID,
    input  logic             BREADY,
    output logic             busy,
`ifdef AW_SCHED_TIMEOUT_EN
    output logic             wlast_err,
    output logic             timeout_err
`else
    output logic             wlast_err
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t             state, state_nxt;
    logic [1:0]         grant_nxt;
    logic               last_m2, last_m2_nxt;   // 1: M2 was served last
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic               wlast_err_nxt;
    logic               aw_hs;
    logic               final_beat;

`ifdef AW_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               timeout_nxt;
`endif

    // Elaboration guard: the timeout limit must fit in its counter.
    if ((TO_MAX >> TO_W) != 0) begin : g_to_max_check
        $error("TO_MAX does not fit in TO_W bits");
    end

    // Next-state, datapath updates and combinational AW handshake.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_m2_nxt   = last_m2;
        len_nxt       = len;
        cnt_nxt       = cnt;
        wlast_err_nxt = 1'b0;
        AWVALID_S     = 1'b0;
        AWREADY_M1    = 1'b0;
        AWREADY_M2    = 1'b0;
        aw_hs         = 1'b0;
        final_beat    = (cnt == len);
`ifdef AW_SCHED_TIMEOUT_EN
        to_cnt_nxt    = to_cnt;
        timeout_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (AWVALID_M1 && AWVALID_M2) begin
                    grant_nxt = last_m2 ? 2'b01 : 2'b10;
                end else if (AWVALID_M1) begin
                    grant_nxt = 2'b01;
                end else if (AWVALID_M2) begin
                    grant_nxt = 2'b10;
                end
                if (AWVALID_M1 || AWVALID_M2) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                AWVALID_S  = (grant[0] & AWVALID_M1) | (grant[1] & AWVALID_M2);
                AWREADY_M1 = AWREADY_S & grant[0];
                AWREADY_M2 = AWREADY_S & grant[1];
                aw_hs      = AWVALID_S & AWREADY_S;
                if (aw_hs) begin
                    len_nxt   = grant[1] ? AWLEN_M2 : AWLEN_M1;
                    cnt_nxt   = '0;
                    state_nxt = DATA;
`ifdef AW_SCHED_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end
            end
            DATA: begin
                // Exit is driven by the beat count; WLAST is only checked.
                if (WVALID && WREADY) begin
                    wlast_err_nxt = (WLAST != final_beat);
                    if (final_beat) begin
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            RESP: begin
                if (BVALID && BREADY) begin
                    last_m2_nxt = grant[1];
                    grant_nxt   = 2'b00;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
`ifdef AW_SCHED_TIMEOUT_EN
        // A completing handshake (state change) wins over the timeout.
        if (state == DATA || state == RESP) begin
            to_cnt_nxt = to_cnt + 1'b1;
            if (to_cnt == TO_W'(TO_MAX) && state_nxt == state) begin
                timeout_nxt = 1'b1;
                last_m2_nxt = grant[1];
                grant_nxt   = 2'b00;
                state_nxt   = IDLE;
            end
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last_m2   <= 1'b1;
            len       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            wlast_err <= 1'b0;
`ifdef AW_SCHED_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last_m2   <= last_m2_nxt;
            len       <= len_nxt;
            cnt       <= cnt_nxt;
            busy      <= (state_nxt != IDLE);
            wlast_err <= wlast_err_nxt;
`ifdef AW_SCHED_TIMEOUT_EN
            to_cnt      <= to_cnt_nxt;
            timeout_err <= timeout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_aw_write_sched.sv
// tb_aw_write_sched: table-driven bench for aw_write_sched. Each table row is
// one clock cycle: inputs are driven at the falling edge, outputs sampled 1ns
// later (state from the previous rising edge plus the combinational AW path).
module tb_aw_write_sched;

    logic       clk;
    logic       rst;
    logic       AWVALID_M1, AWVALID_M2;
    logic [3:0] AWLEN_M1, AWLEN_M2;
    logic       AWREADY_S;
    logic       AWVALID_S, AWREADY_M1, AWREADY_M2;
    logic [1:0] grant;
    logic       WVALID, WREADY, WLAST, BVALID, BREADY;
    logic       busy, wlast_err;
`ifdef AW_SCHED_TIMEOUT_EN
    logic       timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    aw_write_sched dut (
        .clk        (clk),
        .rst        (rst),
        .AWVALID_M1 (AWVALID_M1),
        .AWVALID_M2 (AWVALID_M2),
        .AWLEN_M1   (AWLEN_M1),
        .AWLEN_M2   (AWLEN_M2),
        .AWREADY_S  (AWREADY_S),
        .AWVALID_S  (AWVALID_S),
        .AWREADY_M1 (AWREADY_M1),
        .AWREADY_M2 (AWREADY_M2),
        .grant      (grant),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .WLAST      (WLAST),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .busy       (busy),
`ifdef AW_SCHED_TIMEOUT_EN
        .wlast_err  (wlast_err),
        .timeout_err(timeout_err)
`else
        .wlast_err  (wlast_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, m1, m2;
        logic [3:0] l1, l2;
        logic       ar, wv, wr, wl, bv, br;
        logic       e_awvs, e_ar1, e_ar2;
        logic [1:0] e_grant;
        logic       e_busy, e_werr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, m1, m2, input logic [3:0] l1, l2,
                       input logic ar, wv, wr, wl, bv, br,
                       input logic ea, e1, e2, input logic [1:0] eg,
                       input logic eb, ew);
        vec_t v;
        v.rst = r;  v.m1 = m1; v.m2 = m2; v.l1 = l1; v.l2 = l2;
        v.ar = ar;  v.wv = wv; v.wr = wr; v.wl = wl; v.bv = bv; v.br = br;
        v.e_awvs = ea; v.e_ar1 = e1; v.e_ar2 = e2; v.e_grant = eg;
        v.e_busy = eb; v.e_werr = ew;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic clear_inputs();
        AWVALID_M1 = 1'b0; AWVALID_M2 = 1'b0; AWLEN_M1 = '0; AWLEN_M2 = '0;
        AWREADY_S = 1'b0; WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
        BVALID = 1'b0; BREADY = 1'b0;
    endtask

    initial begin
        logic [1:0] g;

        // Transaction 1: M1 alone, single beat, clean WLAST.
        add(1,1,0,0,0,1, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        add(1,1,0,0,0,1, 0,0,0,0,0, 1,1,0,2'b01,1,0);
        add(1,0,0,0,0,0, 1,1,1,0,0, 0,0,0,2'b01,1,0);
        add(1,0,0,0,0,0, 0,0,0,1,1, 0,0,0,2'b01,1,0);
        add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        // Reset in IDLE restores M1 priority, then 4 contested transactions.
        add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        for (int t = 0; t < 4; t++) begin
            g = (t % 2 == 0) ? 2'b01 : 2'b10;
            add(1,1,1,0,0,1, 0,0,0,0,0, 0,0,0,2'b00,0,0);
            add(1,1,1,0,0,1, 0,0,0,0,0, 1,g[0],g[1],g,1,0);
            add(1,1,1,0,0,1, 1,1,1,0,0, 0,0,0,g,1,0);
            add(1,1,1,0,0,1, 0,0,0,1,1, 0,0,0,g,1,0);
        end
        // M2 len=3: early WLAST on beat 2, missing WLAST on beat 4, W stall.
        add(1,0,1,0,3,1, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        add(1,0,1,0,3,1, 0,0,0,0,0, 1,0,1,2'b10,1,0);
        add(1,0,0,0,3,0, 1,1,0,0,0, 0,0,0,2'b10,1,0);
        add(1,0,0,0,3,0, 1,1,1,0,0, 0,0,0,2'b10,1,0);
        add(1,0,0,0,3,0, 1,0,0,0,0, 0,0,0,2'b10,1,1);
        add(1,0,0,0,3,0, 1,1,0,0,0, 0,0,0,2'b10,1,0);
        add(1,0,0,0,3,0, 1,1,0,0,0, 0,0,0,2'b10,1,0);
        add(1,0,0,0,3,0, 0,0,0,0,0, 0,0,0,2'b10,1,1);
        add(1,0,0,0,3,0, 0,0,0,1,0, 0,0,0,2'b10,1,0);
        add(1,0,0,0,3,0, 0,0,0,1,1, 0,0,0,2'b10,1,0);
        add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        // M1 len=1: slave stalls AW for 5 cycles; final beat overlaps BVALID.
        add(1,1,0,1,0,0, 0,0,0,0,0, 0,0,0,2'b00,0,0);
        for (int k = 0; k < 5; k++) begin
            add(1,1,0,1,0,0, 0,0,0,0,0, 1,0,0,2'b01,1,0);
        end
        add(1,1,0,1,0,1, 0,0,0,0,0, 1,1,0,2'b01,1,0);
        add(1,0,0,1,0,0, 1,1,0,0,0, 0,0,0,2'b01,1,0);
        add(1,0,0,1,0,0, 1,1,1,1,1, 0,0,0,2'b01,1,0);
        add(1,0,0,1,0,0, 0,0,0,1,1, 0,0,0,2'b01,1,0);
        add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,2'b00,0,0);

        // Power-on reset.
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 0, grant, 2'b00);
        chk("rst_busy", 0, {1'b0, busy}, 2'b00);
        chk("rst_wlast_err", 0, {1'b0, wlast_err}, 2'b00);
        chk("rst_awvalid_s", 0, {1'b0, AWVALID_S}, 2'b00);
        chk("rst_awready", 0, {AWREADY_M2, AWREADY_M1}, 2'b00);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            AWVALID_M1 = vecs[i].m1; AWVALID_M2 = vecs[i].m2;
            AWLEN_M1 = vecs[i].l1;   AWLEN_M2 = vecs[i].l2;
            AWREADY_S = vecs[i].ar;
            WVALID = vecs[i].wv; WREADY = vecs[i].wr; WLAST = vecs[i].wl;
            BVALID = vecs[i].bv; BREADY = vecs[i].br;
            #1;
            chk("awvalid_s", i, {1'b0, AWVALID_S}, {1'b0, vecs[i].e_awvs});
            chk("awready_m1", i, {1'b0, AWREADY_M1}, {1'b0, vecs[i].e_ar1});
            chk("awready_m2", i, {1'b0, AWREADY_M2}, {1'b0, vecs[i].e_ar2});
            chk("grant", i, grant, vecs[i].e_grant);
            chk("busy", i, {1'b0, busy}, {1'b0, vecs[i].e_busy});
            chk("wlast_err", i, {1'b0, wlast_err}, {1'b0, vecs[i].e_werr});
        end

        // Reset during a burst: M1 was served last, so M2 wins now; after the
        // abort the pointer is back to M1-first.
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        AWVALID_M1 = 1'b1; AWVALID_M2 = 1'b1; AWLEN_M2 = 4'd3; AWREADY_S = 1'b1;
        #1;
        chk("mid_idle_grant", 0, grant, 2'b00);
        @(negedge clk);
        #1;
        chk("mid_rr_grant", 0, grant, 2'b10);
        @(negedge clk);
        AWVALID_M1 = 1'b0; AWVALID_M2 = 1'b0;
        WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b1;
        #1;
        chk("mid_data_busy", 0, {1'b0, busy}, 2'b01);
        @(negedge clk);
        rst = 1'b0; WLAST = 1'b0;
        #1;
        chk("mid_werr_pulse", 0, {1'b0, wlast_err}, 2'b01);
        @(negedge clk);
        rst = 1'b1; WVALID = 1'b0; WREADY = 1'b0;
        #1;
        chk("mid_rst_grant", 0, grant, 2'b00);
        chk("mid_rst_busy", 0, {1'b0, busy}, 2'b00);
        chk("mid_rst_werr", 0, {1'b0, wlast_err}, 2'b00);
        chk("mid_rst_awvalid_s", 0, {1'b0, AWVALID_S}, 2'b00);
        AWVALID_M1 = 1'b1; AWVALID_M2 = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rearb_grant", 0, grant, 2'b01);
        chk("mid_rearb_awready", 0, {AWREADY_M2, AWREADY_M1}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
